// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single outstanding word requests to
// instruction memory and hands the returned word plus its PC to decode/extend.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imemReqValid,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemReqReady,
  input  logic        i_imemRspValid,
  input  logic [31:0] i_imemRspData,
  output logic        o_instrValid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic [31:0] o_pcPlus4,
  input  logic        i_instrReady,
  input  logic        i_redirectValid,
  input  logic [31:0] i_redirectTarget
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic              instr_valid_q, instr_valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic [XLEN-1:0]   out_pc4_q, out_pc4_d;

  logic [XLEN-1:0]   redirect_pc;
  logic              unused_tgt_lsb;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign redirect_pc    = {i_redirectTarget[XLEN-1:2], 2'b00};
  assign unused_tgt_lsb = ^i_redirectTarget[1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      kill_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      out_pc_q      <= RESET_PC;
      out_pc4_q     <= RESET_PC + PC_STEP;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      kill_q        <= kill_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      out_pc_q      <= out_pc_d;
      out_pc4_q     <= out_pc4_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    kill_d        = kill_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    out_pc_d      = out_pc_q;
    out_pc4_d     = out_pc4_q;

    unique case (state_q)
      ST_REQ: begin
        if (i_redirectValid) begin
          pc_d = redirect_pc;
        end
        // A redirect landing on the accept edge poisons the in-flight response.
        if (i_imemReqReady) begin
          state_d = ST_WAIT;
          kill_d  = i_redirectValid;
        end
      end

      ST_WAIT: begin
        if (i_imemRspValid) begin
          if (kill_q || i_redirectValid) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            instr_d       = i_imemRspData;
            out_pc_d      = pc_q;
            out_pc4_d     = pc_q + PC_STEP;
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end
        if (i_redirectValid) begin
          pc_d = redirect_pc;
          if (!i_imemRspValid) begin
            kill_d = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        // Redirect wins over sequential advance, consumed or not.
        if (i_redirectValid) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
          state_d       = ST_REQ;
        end else if (i_instrReady) begin
          instr_valid_d = 1'b0;
          pc_d          = pc_q + PC_STEP;
          state_d       = ST_REQ;
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  assign o_imemReqValid = (state_q == ST_REQ) && !i_rst;
  assign o_imemAddr     = pc_q;
  assign o_instrValid   = instr_valid_q;
  assign o_instruction  = instr_q;
  assign o_pc           = out_pc_q;
  assign o_pcPlus4      = out_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural memory answers requests, expected
// request addresses and delivered PCs are queued by each scenario and checked on handshakes.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        mem_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        tb_pulse;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] tgt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mem_lat = 1;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  int          cons_q[$];

  assign rsp_valid = mem_rsp_valid | tb_pulse;
  assign rsp_data  = tb_pulse ? 32'hDEAD_BEEF : mem_rsp_data;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imemReqValid   (req_valid),
    .o_imemAddr       (req_addr),
    .i_imemReqReady   (mem_ready),
    .i_imemRspValid   (rsp_valid),
    .i_imemRspData    (rsp_data),
    .o_instrValid     (instr_valid),
    .o_instruction    (instruction),
    .o_pc             (pc_out),
    .o_pcPlus4        (pc4_out),
    .i_instrReady     (instr_ready),
    .i_redirectValid  (redirect),
    .i_redirectTarget (tgt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h00A0_0093 ^ {a[23:0], 8'h00};
  endfunction

  // Memory model: one response per accepted request after mem_lat cycles.
  logic        rsp_pend;
  int          rsp_cnt;
  logic [31:0] rsp_addr;
  always @(posedge clk) begin
    if (rst) begin
      rsp_pend = 1'b0;
      rsp_cnt  = 0;
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= 32'h0;
    end else begin
      mem_rsp_valid <= 1'b0;
      if (rsp_pend) begin
        rsp_cnt = rsp_cnt - 1;
        if (rsp_cnt <= 0) begin
          mem_rsp_valid <= 1'b1;
          mem_rsp_data  <= word(rsp_addr);
          rsp_pend = 1'b0;
        end
      end
      if (req_valid && mem_ready) begin
        rsp_addr = req_addr;
        if (mem_lat <= 1) begin
          mem_rsp_valid <= 1'b1;
          mem_rsp_data  <= word(req_addr);
        end else begin
          rsp_pend = 1'b1;
          rsp_cnt  = mem_lat - 1;
        end
      end
    end
  end

  // Scoreboard: check request addresses on accept and deliveries on consume.
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [31:0] ep;
    if (!rst) begin
      if (req_valid && mem_ready && exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        total++;
        if (req_addr !== ea) begin
          bad++;
          $display("FAIL req_addr got=%h exp=%h t=%0t", req_addr, ea, $time);
        end
      end
      if (instr_valid && instr_ready) begin
        cons_q.push_back(cyc);
        if (exp_pc_q.size() > 0) begin
          ep = exp_pc_q.pop_front();
          total++;
          if ({pc_out, pc4_out, instruction} !== {ep, ep + 32'd4, word(ep)}) begin
            bad++;
            $display("FAIL deliver got pc=%h pc4=%h ins=%h exp pc=%h pc4=%h ins=%h",
                     pc_out, pc4_out, instruction, ep, ep + 32'd4, word(ep));
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    redirect = 1'b0;
    tgt = 32'h0;
    tb_pulse = 1'b0;
    exp_addr_q.delete();
    exp_pc_q.delete();
    cons_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (exp_addr_q.size() == 0 && exp_pc_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    instr_ready = 1'b1;
    do_reset();
    @(negedge clk);
    total++;
    if ({req_valid, instr_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_valids got=%b exp=00", {req_valid, instr_valid});
    end
    total++;
    if ({instruction, pc_out, pc4_out} !== {32'h0, 32'h0, 32'h4}) begin
      bad++;
      $display("FAIL reset_regs got ins=%h pc=%h pc4=%h exp 0/0/4", instruction, pc_out, pc4_out);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    do_reset();
    mem_ready = 1'b1;
    instr_ready = 1'b1;
    mem_lat = 1;
    exp_addr_q = '{32'h0, 32'h4, 32'h8};
    exp_pc_q   = '{32'h0, 32'h4, 32'h8};
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({req_valid, req_addr} !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL first_req got v=%b a=%h exp v=1 a=0", req_valid, req_addr);
    end
    wait_drain(40, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL seq_drain got left=%0d exp left=0", exp_addr_q.size() + exp_pc_q.size());
    end
    total++;
    if (cons_q.size() < 3 || cons_q[1] - cons_q[0] != 3 || cons_q[2] - cons_q[1] != 3) begin
      bad++;
      $display("FAIL throughput got n=%0d exp 3 consumes spaced by 3", cons_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] i0, p0;
    do_reset();
    mem_ready = 1'b1;
    instr_ready = 1'b0;
    mem_lat = 1;
    exp_addr_q = '{32'h0, 32'h4};
    exp_pc_q   = '{32'h0};
    rst = 1'b0;
    wait_valid(20, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_valid got=0 exp=1");
    end
    i0 = instruction;
    p0 = pc_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({instr_valid, req_valid, instruction, pc_out} !== {1'b1, 1'b0, i0, p0}) begin
        bad++;
        $display("FAIL bp_hold got v=%b rv=%b ins=%h pc=%h exp v=1 rv=0 ins=%h pc=%h",
                 instr_valid, req_valid, instruction, pc_out, i0, p0);
      end
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    wait_drain(20, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_drain got left=%0d exp left=0", exp_addr_q.size() + exp_pc_q.size());
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    do_reset();
    mem_ready = 1'b1;
    instr_ready = 1'b1;
    mem_lat = 2;
    exp_addr_q = '{32'h0, 32'h100};
    exp_pc_q   = '{32'h100};
    rst = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_valid && mem_ready) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rw_accept got=0 exp=1");
    end
    @(posedge clk);
    #1;
    redirect = 1'b1;
    tgt = 32'h100;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL rw_dropped got v=%b exp v=0", instr_valid);
      end
    end
    wait_drain(30, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rw_drain got left=%0d exp left=0", exp_addr_q.size() + exp_pc_q.size());
    end
    mem_lat = 1;
  endtask

  task automatic test_redirect_accept();
    bit ok;
    do_reset();
    mem_ready = 1'b1;
    instr_ready = 1'b1;
    mem_lat = 1;
    redirect = 1'b1;
    tgt = 32'h40;
    exp_addr_q = '{32'h0, 32'h40};
    exp_pc_q   = '{32'h40};
    rst = 1'b0;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL ra_dropped got v=%b exp v=0", instr_valid);
      end
    end
    wait_drain(30, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ra_drain got left=%0d exp left=0", exp_addr_q.size() + exp_pc_q.size());
    end
  endtask

  task automatic test_redirect_hold();
    bit ok;
    do_reset();
    mem_ready = 1'b1;
    instr_ready = 1'b0;
    mem_lat = 1;
    exp_addr_q = '{32'h0, 32'h80};
    exp_pc_q   = '{32'h0};
    rst = 1'b0;
    wait_valid(20, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rh_valid got=0 exp=1");
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    redirect = 1'b1;
    tgt = 32'h80;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({instr_valid, req_valid, req_addr} !== {1'b0, 1'b1, 32'h80}) begin
      bad++;
      $display("FAIL rh_next got v=%b rv=%b a=%h exp v=0 rv=1 a=00000080",
               instr_valid, req_valid, req_addr);
    end
    wait_drain(20, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rh_drain got left=%0d exp left=0", exp_addr_q.size() + exp_pc_q.size());
    end
  endtask

  task automatic test_align_wrap();
    bit ok;
    do_reset();
    mem_ready = 1'b0;
    instr_ready = 1'b1;
    mem_lat = 1;
    redirect = 1'b1;
    tgt = 32'h0000_0103;
    rst = 1'b0;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    total++;
    if ({req_valid, req_addr} !== {1'b1, 32'h100}) begin
      bad++;
      $display("FAIL align got v=%b a=%h exp v=1 a=00000100", req_valid, req_addr);
    end
    @(posedge clk);
    #1;
    redirect = 1'b1;
    tgt = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    exp_addr_q = '{32'hFFFF_FFFC, 32'h0};
    exp_pc_q   = '{32'hFFFF_FFFC};
    mem_ready = 1'b1;
    wait_drain(30, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wrap_drain got left=%0d exp left=0", exp_addr_q.size() + exp_pc_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    mem_ready = 1'b0;
    instr_ready = 1'b1;
    mem_lat = 3;
    redirect = 1'b1;
    tgt = 32'h200;
    rst = 1'b0;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    mem_ready = 1'b1;
    exp_addr_q = '{32'h200, 32'h204};
    exp_pc_q   = '{32'h200};
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (exp_addr_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || exp_pc_q.size() != 0) begin
      bad++;
      $display("FAIL rm_reach got left=%0d exp left=0", exp_addr_q.size() + exp_pc_q.size());
    end
    #3;
    total++;
    if ({instruction, pc_out} !== {word(32'h200), 32'h200}) begin
      bad++;
      $display("FAIL rm_before got ins=%h pc=%h exp ins=%h pc=00000200", instruction, pc_out, word(32'h200));
    end
    rst = 1'b1;
    #1;
    total++;
    if ({req_valid, instr_valid, instruction, pc_out, pc4_out} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h4}) begin
      bad++;
      $display("FAIL rm_async got rv=%b v=%b ins=%h pc=%h pc4=%h exp 0/0/0/0/4",
               req_valid, instr_valid, instruction, pc_out, pc4_out);
    end
    exp_addr_q.delete();
    exp_pc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    mem_lat = 1;
    mem_ready = 1'b1;
    tb_pulse = 1'b1;
    exp_addr_q = '{32'h0};
    exp_pc_q   = '{32'h0};
    rst = 1'b0;
    @(posedge clk);
    #1;
    tb_pulse = 1'b0;
    wait_drain(20, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rm_drain got left=%0d exp left=0", exp_addr_q.size() + exp_pc_q.size());
    end
  endtask

  initial begin
    mem_ready = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    tgt = 32'h0;
    tb_pulse = 1'b0;
    #1;
    rst = 1'b1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_accept();
    test_redirect_hold();
    test_align_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
